// File: rtl/vga_pkg.sv
// Shared timing constants and widths for the VGA frame-buffer reader.
package vga_pkg;

  localparam int unsigned H_ACTIVE  = 640;
  localparam int unsigned H_FP      = 16;
  localparam int unsigned H_SYNC    = 96;
  localparam int unsigned H_BP      = 48;
  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int unsigned V_ACTIVE  = 480;
  localparam int unsigned V_FP      = 10;
  localparam int unsigned V_SYNC    = 2;
  localparam int unsigned V_BP      = 33;
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int unsigned LOGICAL_W = 160;
  localparam int unsigned LOGICAL_H = 120;

  localparam int unsigned ADDR_W    = 15;
  localparam int unsigned COLOUR_W  = 3;
  localparam int unsigned CNT_W     = 10;

endpackage

// File: rtl/vga_frame_reader_if.sv
// Frame-buffer read port plus VGA output bundle of the frame reader.
interface vga_frame_reader_if;
  import vga_pkg::*;

  logic [ADDR_W-1:0]   rd_addr;
  logic [COLOUR_W-1:0] rd_data;
  logic [COLOUR_W-1:0] vga_colour;
  logic                vga_hs;
  logic                vga_vs;
  logic                vga_blank_n;
  logic                vga_pix_en;
  logic                frame_start;

  modport master (
    output rd_addr, vga_colour, vga_hs, vga_vs, vga_blank_n, vga_pix_en, frame_start,
    input  rd_data
  );

  modport slave (
    input  rd_addr, vga_colour, vga_hs, vga_vs, vga_blank_n, vga_pix_en, frame_start,
    output rd_data
  );

endinterface

// File: rtl/vga_timing_counter.sv
// Horizontal/vertical scan counters with active, sync and frame-wrap decode.
module vga_timing_counter
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             tick,
  output logic [CNT_W-1:0] h,
  output logic [CNT_W-1:0] v,
  output logic             active_c,
  output logic             hs_c,
  output logic             vs_c,
  output logic             wrap_c
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  logic h_last_c;
  logic v_last_c;

  // Region decode from the current counter position.
  always_comb begin
    h_last_c = (h == CNT_W'(H_TOT - 1));
    v_last_c = (v == CNT_W'(V_TOT - 1));
    active_c = (h < CNT_W'(H_ACTIVE)) && (v < CNT_W'(V_ACTIVE));
    hs_c     = !((h >= CNT_W'(H_ACTIVE + H_FP)) && (h < CNT_W'(H_ACTIVE + H_FP + H_SYNC)));
    vs_c     = !((v >= CNT_W'(V_ACTIVE + V_FP)) && (v < CNT_W'(V_ACTIVE + V_FP + V_SYNC)));
    wrap_c   = tick && h_last_c && v_last_c;
  end

  // Counters advance on pixel ticks; dropping enable restarts the scan at (0,0).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      h <= '0;
      v <= '0;
    end else if (!enable) begin
      h <= '0;
      v <= '0;
    end else if (tick) begin
      if (h_last_c) begin
        h <= '0;
        v <= v_last_c ? '0 : v + CNT_W'(1);
      end else begin
        h <= h + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/vga_frame_reader.sv
// Scans the 160x120 frame buffer and drives 640x480@60 VGA, 4x4 pixel blocks.
// Optional macro VGA_FRAME_READER_BORDER_EN draws a white play-field border.
module vga_frame_reader
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = vga_pkg::H_ACTIVE,
  parameter int unsigned H_FP     = vga_pkg::H_FP,
  parameter int unsigned H_SYNC   = vga_pkg::H_SYNC,
  parameter int unsigned H_BP     = vga_pkg::H_BP,
  parameter int unsigned V_ACTIVE = vga_pkg::V_ACTIVE,
  parameter int unsigned V_FP     = vga_pkg::V_FP,
  parameter int unsigned V_SYNC   = vga_pkg::V_SYNC,
  parameter int unsigned V_BP     = vga_pkg::V_BP
) (
  input logic                clk,
  input logic                resetn,
  input logic                enable,
  vga_frame_reader_if.master bus
);

  logic                phase;
  logic                started;
  logic                tick_c;
  logic [CNT_W-1:0]    h;
  logic [CNT_W-1:0]    v;
  logic [CNT_W-1:0]    x_c;
  logic [CNT_W-1:0]    y_c;
  logic                active_c;
  logic                hs_c;
  logic                vs_c;
  logic                wrap_c;
  logic [ADDR_W-1:0]   addr_c;
  logic [COLOUR_W-1:0] colour_c;
  logic                s1_active;
  logic                s1_hs;
  logic                s1_vs;
`ifdef VGA_FRAME_READER_BORDER_EN
  logic                border_c;
  logic                s1_border;
`endif

  assign tick_c         = phase;
  assign bus.vga_pix_en = phase;

  // Pixel-tick toggle and first-tick-after-enable tracking.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      phase   <= 1'b0;
      started <= 1'b0;
    end else if (!enable) begin
      phase   <= 1'b0;
      started <= 1'b0;
    end else begin
      phase <= ~phase;
      if (phase) started <= 1'b1;
    end
  end

  vga_timing_counter #(
    .H_ACTIVE (H_ACTIVE),
    .H_FP     (H_FP),
    .H_SYNC   (H_SYNC),
    .H_BP     (H_BP),
    .V_ACTIVE (V_ACTIVE),
    .V_FP     (V_FP),
    .V_SYNC   (V_SYNC),
    .V_BP     (V_BP)
  ) u_timing (
    .clk      (clk),
    .resetn   (resetn),
    .enable   (enable),
    .tick     (tick_c),
    .h        (h),
    .v        (v),
    .active_c (active_c),
    .hs_c     (hs_c),
    .vs_c     (vs_c),
    .wrap_c   (wrap_c)
  );

  // Logical pixel address y*160+x as shift-add, and stage-2 colour source.
  always_comb begin
    x_c    = h >> 2;
    y_c    = v >> 2;
    addr_c = (ADDR_W'(y_c) << 7) + (ADDR_W'(y_c) << 5) + ADDR_W'(x_c);
`ifdef VGA_FRAME_READER_BORDER_EN
    border_c = (x_c == '0) || (x_c == CNT_W'(LOGICAL_W - 1)) ||
               (y_c == '0) || (y_c == CNT_W'(LOGICAL_H - 1));
    colour_c = s1_border ? '1 : bus.rd_data;
`else
    colour_c = bus.rd_data;
`endif
  end

  // Two-stage pipeline: address/flags, then RAM data aligned with sync/blank.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus.rd_addr     <= '0;
      s1_active       <= 1'b0;
      s1_hs           <= 1'b1;
      s1_vs           <= 1'b1;
      bus.vga_colour  <= '0;
      bus.vga_hs      <= 1'b1;
      bus.vga_vs      <= 1'b1;
      bus.vga_blank_n <= 1'b0;
      bus.frame_start <= 1'b0;
`ifdef VGA_FRAME_READER_BORDER_EN
      s1_border       <= 1'b0;
`endif
    end else if (!enable) begin
      bus.rd_addr     <= '0;
      s1_active       <= 1'b0;
      s1_hs           <= 1'b1;
      s1_vs           <= 1'b1;
      bus.vga_colour  <= '0;
      bus.vga_hs      <= 1'b1;
      bus.vga_vs      <= 1'b1;
      bus.vga_blank_n <= 1'b0;
      bus.frame_start <= 1'b0;
`ifdef VGA_FRAME_READER_BORDER_EN
      s1_border       <= 1'b0;
`endif
    end else begin
      bus.frame_start <= tick_c && (wrap_c || !started);
      if (tick_c) begin
        if (active_c) bus.rd_addr <= addr_c;
        s1_active       <= active_c;
        s1_hs           <= hs_c;
        s1_vs           <= vs_c;
`ifdef VGA_FRAME_READER_BORDER_EN
        s1_border       <= border_c;
`endif
        bus.vga_colour  <= s1_active ? colour_c : '0;
        bus.vga_hs      <= s1_hs;
        bus.vga_vs      <= s1_vs;
        bus.vga_blank_n <= s1_active;
      end
    end
  end

endmodule

// File: tb/tb_vga_frame_reader.sv
// Directed bench: full-size reader for line/address/enable behaviour,
// shrunken-timing reader for whole-frame behaviour.
module tb_vga_frame_reader;

  logic clk = 1'b0;
  logic resetn;
  logic en_a;
  logic en_b;
  int   cyc = 0;
  int   base = 0;
  int   checks = 0;
  int   passed = 0;

  always #10 clk = ~clk;

  vga_frame_reader_if bus_a ();
  vga_frame_reader_if bus_b ();

  vga_frame_reader u_a (
    .clk    (clk),
    .resetn (resetn),
    .enable (en_a),
    .bus    (bus_a)
  );

  vga_frame_reader #(
    .H_ACTIVE (16), .H_FP (2), .H_SYNC (4), .H_BP (2),
    .V_ACTIVE (8),  .V_FP (2), .V_SYNC (2), .V_BP (2)
  ) u_b (
    .clk    (clk),
    .resetn (resetn),
    .enable (en_b),
    .bus    (bus_b)
  );

  // Synchronous RAM models returning addr[2:0] one clk after the address.
  always @(posedge clk) begin
    bus_a.rd_data <= bus_a.rd_addr[2:0];
    bus_b.rd_data <= bus_b.rd_addr[2:0];
    cyc           <= cyc + 1;
  end

  // Stop at the negedge following edge base+n.
  task automatic wait_edge(input int n);
    while (cyc - base < n) @(negedge clk);
  endtask

  // Bounded wait for a frame_start pulse; base marks the edge that raised it.
  task automatic sync_fs(input bit use_b, input string name);
    int n = 0;
    bit seen = 1'b0;
    while (!seen && n < 3000) begin
      @(negedge clk);
      n++;
      seen = use_b ? bus_b.frame_start : bus_a.frame_start;
    end
    checks++; if (!seen) $display("FAIL sync_%s: frame_start got 0 within %0d clk, want 1", name, n); else passed++;
    base = cyc;
  endtask

  task automatic test_reset();
    resetn = 1'b0; en_a = 1'b1; en_b = 1'b1;
    #35;
    checks++; if (bus_a.vga_hs !== 1'b1) $display("FAIL por_hs: got %b want 1", bus_a.vga_hs); else passed++;
    checks++; if (bus_a.vga_vs !== 1'b1) $display("FAIL por_vs: got %b want 1", bus_a.vga_vs); else passed++;
    checks++; if (bus_a.vga_blank_n !== 1'b0) $display("FAIL por_blank: got %b want 0", bus_a.vga_blank_n); else passed++;
    checks++; if (bus_a.rd_addr !== 15'd0) $display("FAIL por_addr: got %0d want 0", bus_a.rd_addr); else passed++;
    @(negedge clk); resetn = 1'b1;
    sync_fs(1'b0, "a_por");
    // (250,0) in stage 1, (249,0) at the outputs
    wait_edge(500);
    checks++; if (bus_a.rd_addr !== 15'd62) $display("FAIL pre_addr: got %0d want 62", bus_a.rd_addr); else passed++;
    checks++; if (bus_a.vga_blank_n !== 1'b1) $display("FAIL pre_blank: got %b want 1", bus_a.vga_blank_n); else passed++;
    checks++; if (bus_a.vga_colour !== 3'd6) $display("FAIL pre_colour: got %0d want 6", bus_a.vga_colour); else passed++;
    #3 resetn = 1'b0;
    #1;
    checks++; if (bus_a.vga_hs !== 1'b1) $display("FAIL arst_hs: got %b want 1", bus_a.vga_hs); else passed++;
    checks++; if (bus_a.vga_vs !== 1'b1) $display("FAIL arst_vs: got %b want 1", bus_a.vga_vs); else passed++;
    checks++; if (bus_a.vga_blank_n !== 1'b0) $display("FAIL arst_blank: got %b want 0", bus_a.vga_blank_n); else passed++;
    checks++; if (bus_a.vga_colour !== 3'd0) $display("FAIL arst_colour: got %0d want 0", bus_a.vga_colour); else passed++;
    checks++; if (bus_a.rd_addr !== 15'd0) $display("FAIL arst_addr: got %0d want 0", bus_a.rd_addr); else passed++;
    checks++; if (bus_a.frame_start !== 1'b0) $display("FAIL arst_fs: got %b want 0", bus_a.frame_start); else passed++;
    checks++; if (bus_a.vga_pix_en !== 1'b0) $display("FAIL arst_pix_en: got %b want 0", bus_a.vga_pix_en); else passed++;
    @(negedge clk); resetn = 1'b1;
    sync_fs(1'b0, "a_run");
  endtask

  task automatic test_line_timing();
    int hs_fall = -1, hs_fall2 = -1, hs_rise = -1, bl_rise = -1, bl_fall = -1, pix_hi = 0;
    logic p_hs = bus_a.vga_hs;
    logic p_bl = bus_a.vga_blank_n;
    for (int k = 1; k <= 3400; k++) begin
      wait_edge(k);
      if (p_hs && !bus_a.vga_hs) begin
        if (hs_fall < 0) hs_fall = k; else if (hs_fall2 < 0) hs_fall2 = k;
      end
      if (!p_hs && bus_a.vga_hs && hs_fall >= 0 && hs_rise < 0) hs_rise = k;
      if (!p_bl && bus_a.vga_blank_n && bl_rise < 0) bl_rise = k;
      if (p_bl && !bus_a.vga_blank_n && bl_rise >= 0 && bl_fall < 0) bl_fall = k;
      if (bus_a.vga_pix_en) pix_hi++;
      p_hs = bus_a.vga_hs;
      p_bl = bus_a.vga_blank_n;
    end
    checks++; if (hs_fall !== 1314) $display("FAIL hs_start: edge %0d want 1314", hs_fall); else passed++;
    checks++; if (hs_rise - hs_fall !== 192) $display("FAIL hs_width: got %0d clk want 192", hs_rise - hs_fall); else passed++;
    checks++; if (hs_fall2 - hs_fall !== 1600) $display("FAIL hs_period: got %0d clk want 1600", hs_fall2 - hs_fall); else passed++;
    checks++; if (bl_rise !== 2) $display("FAIL blank_start: edge %0d want 2", bl_rise); else passed++;
    checks++; if (bl_fall - bl_rise !== 1280) $display("FAIL blank_width: got %0d clk want 1280", bl_fall - bl_rise); else passed++;
    checks++; if (pix_hi !== 1700) $display("FAIL pix_en_count: got %0d want 1700", pix_hi); else passed++;
  endtask

  task automatic test_addressing();
    wait_edge(4806);  // (3,3)
    checks++; if (bus_a.rd_addr !== 15'd0) $display("FAIL addr_3_3: got %0d want 0", bus_a.rd_addr); else passed++;
    wait_edge(6416);  // (8,4)
    checks++; if (bus_a.rd_addr !== 15'd162) $display("FAIL addr_8_4: got %0d want 162", bus_a.rd_addr); else passed++;
    wait_edge(6418);
    checks++; if (bus_a.vga_colour !== 3'd2) $display("FAIL colour_8_4: got %0d want 2", bus_a.vga_colour); else passed++;
    checks++; if (bus_a.vga_blank_n !== 1'b1) $display("FAIL blank_8_4: got %b want 1", bus_a.vga_blank_n); else passed++;
    wait_edge(7678);  // (639,4), last active pixel of the line
    checks++; if (bus_a.rd_addr !== 15'd319) $display("FAIL addr_639_4: got %0d want 319", bus_a.rd_addr); else passed++;
    wait_edge(7680);
    checks++; if (bus_a.vga_colour !== 3'd7) $display("FAIL colour_639_4: got %0d want 7", bus_a.vga_colour); else passed++;
    wait_edge(7800);  // (700,4) in stage 1: address holds
    checks++; if (bus_a.rd_addr !== 15'd319) $display("FAIL addr_hold: got %0d want 319", bus_a.rd_addr); else passed++;
    wait_edge(7802);
    checks++; if (bus_a.vga_colour !== 3'd0) $display("FAIL colour_700: got %0d want 0", bus_a.vga_colour); else passed++;
    checks++; if (bus_a.vga_blank_n !== 1'b0) $display("FAIL blank_700: got %b want 0", bus_a.vga_blank_n); else passed++;
    checks++; if (bus_a.vga_hs !== 1'b0) $display("FAIL hs_700: got %b want 0", bus_a.vga_hs); else passed++;
  endtask

  task automatic test_enable_drop();
    int t0;
    wait_edge(8599);  // counters at (300,5)
    checks++; if (bus_a.rd_addr !== 15'd234) $display("FAIL pre_drop_addr: got %0d want 234", bus_a.rd_addr); else passed++;
    checks++; if (bus_a.vga_pix_en !== 1'b1) $display("FAIL pre_drop_pix_en: got %b want 1", bus_a.vga_pix_en); else passed++;
    en_a = 1'b0;
    @(negedge clk);
    checks++; if (bus_a.vga_hs !== 1'b1) $display("FAIL drop_hs: got %b want 1", bus_a.vga_hs); else passed++;
    checks++; if (bus_a.vga_vs !== 1'b1) $display("FAIL drop_vs: got %b want 1", bus_a.vga_vs); else passed++;
    checks++; if (bus_a.vga_blank_n !== 1'b0) $display("FAIL drop_blank: got %b want 0", bus_a.vga_blank_n); else passed++;
    checks++; if (bus_a.vga_colour !== 3'd0) $display("FAIL drop_colour: got %0d want 0", bus_a.vga_colour); else passed++;
    checks++; if (bus_a.rd_addr !== 15'd0) $display("FAIL drop_addr: got %0d want 0", bus_a.rd_addr); else passed++;
    checks++; if (bus_a.vga_pix_en !== 1'b0) $display("FAIL drop_pix_en: got %b want 0", bus_a.vga_pix_en); else passed++;
    repeat (3) @(negedge clk);
    t0 = cyc;
    en_a = 1'b1;
    sync_fs(1'b0, "a_reenable");
    checks++; if (base - t0 !== 2) $display("FAIL reen_fs_latency: got %0d clk want 2", base - t0); else passed++;
    wait_edge(1);
    checks++; if (bus_a.frame_start !== 1'b0) $display("FAIL reen_fs_width: got %b want 0", bus_a.frame_start); else passed++;
    wait_edge(2);
    checks++; if (bus_a.vga_blank_n !== 1'b1) $display("FAIL reen_blank: got %b want 1", bus_a.vga_blank_n); else passed++;
    checks++; if (bus_a.vga_colour !== 3'd0) $display("FAIL reen_colour0: got %0d want 0", bus_a.vga_colour); else passed++;
    wait_edge(8);
    checks++; if (bus_a.rd_addr !== 15'd1) $display("FAIL reen_addr_4_0: got %0d want 1", bus_a.rd_addr); else passed++;
    wait_edge(10);
    checks++; if (bus_a.vga_colour !== 3'd1) $display("FAIL reen_colour_4_0: got %0d want 1", bus_a.vga_colour); else passed++;
  endtask

  task automatic test_frame_timing();
    int vs_fall = -1, vs_rise = -1, hs_fall = -1, hs_rise = -1, bl_rise = -1, bl_fall = -1;
    int fs_at = -1, fs_cnt = 0;
    logic p_vs, p_hs, p_bl;
    sync_fs(1'b1, "b_first");
    @(negedge clk);
    sync_fs(1'b1, "b_wrap");
    p_vs = bus_b.vga_vs; p_hs = bus_b.vga_hs; p_bl = bus_b.vga_blank_n;
    for (int k = 1; k <= 700; k++) begin
      wait_edge(k);
      if (p_vs && !bus_b.vga_vs && vs_fall < 0) vs_fall = k;
      if (!p_vs && bus_b.vga_vs && vs_fall >= 0 && vs_rise < 0) vs_rise = k;
      if (p_hs && !bus_b.vga_hs && hs_fall < 0) hs_fall = k;
      if (!p_hs && bus_b.vga_hs && hs_fall >= 0 && hs_rise < 0) hs_rise = k;
      if (!p_bl && bus_b.vga_blank_n && bl_rise < 0) bl_rise = k;
      if (p_bl && !bus_b.vga_blank_n && bl_rise >= 0 && bl_fall < 0) bl_fall = k;
      if (bus_b.frame_start) begin
        fs_cnt++;
        if (fs_at < 0) fs_at = k;
      end
      if (k == 368) begin
        checks++; if (bus_b.rd_addr !== 15'd163) $display("FAIL b_addr_15_7: got %0d want 163", bus_b.rd_addr); else passed++;
      end
      if (k == 370) begin
        checks++; if (bus_b.vga_colour !== 3'd3) $display("FAIL b_colour_15_7: got %0d want 3", bus_b.vga_colour); else passed++;
      end
      if (k == 372) begin
        checks++; if (bus_b.vga_blank_n !== 1'b0) $display("FAIL b_blank_16_7: got %b want 0", bus_b.vga_blank_n); else passed++;
      end
      p_vs = bus_b.vga_vs; p_hs = bus_b.vga_hs; p_bl = bus_b.vga_blank_n;
    end
    checks++; if (vs_fall !== 484) $display("FAIL vs_start: edge %0d want 484", vs_fall); else passed++;
    checks++; if (vs_rise - vs_fall !== 96) $display("FAIL vs_width: got %0d clk want 96", vs_rise - vs_fall); else passed++;
    checks++; if (fs_at !== 672) $display("FAIL fs_period: got %0d clk want 672", fs_at); else passed++;
    checks++; if (fs_cnt !== 1) $display("FAIL fs_width: got %0d clk high want 1", fs_cnt); else passed++;
    checks++; if (hs_fall !== 40) $display("FAIL b_hs_start: edge %0d want 40", hs_fall); else passed++;
    checks++; if (hs_rise - hs_fall !== 8) $display("FAIL b_hs_width: got %0d clk want 8", hs_rise - hs_fall); else passed++;
    checks++; if (bl_rise !== 4) $display("FAIL b_blank_start: edge %0d want 4", bl_rise); else passed++;
    checks++; if (bl_fall - bl_rise !== 32) $display("FAIL b_blank_width: got %0d clk want 32", bl_fall - bl_rise); else passed++;
  endtask

  initial begin
    test_reset();
    test_line_timing();
    test_addressing();
    test_enable_drop();
    test_frame_timing();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/vga_frame_reader.md
Name: vga_frame_reader

Overview:
Reader end of the game's pixel-plot path. The screen updater writes 3-bit colours into a 160x120 frame-buffer RAM. This block scans that RAM and produces 640x480@60 VGA timing, with each logical pixel shown as a 4x4 block. It also emits a frame_start pulse so the game datapath can time its gravity and collision updates between frames.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in pixel ticks
- H_SYNC, 96, hsync width in pixel ticks
- H_BP, 48, horizontal back porch in pixel ticks
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vsync width in lines
- V_BP, 33, vertical back porch in lines
- COLOUR_W, 3, frame-buffer colour width

Ports:
- clk  in  1  50 MHz system clock
- resetn  in  1  asynchronous, active-low reset
- enable  in  1  scan enable; low holds the block idle
- rd_addr  out  15  frame-buffer read address, y*160+x
- rd_data  in  COLOUR_W  RAM read data; valid 1 clk after rd_addr
- vga_colour  out  COLOUR_W  pixel colour to DAC
- vga_hs  out  1  hsync, active low
- vga_vs  out  1  vsync, active low
- vga_blank_n  out  1  low outside the active area
- vga_pix_en  out  1  pixel tick (25 MHz enable), high every second clk
- frame_start  out  1  one-clk pulse at the start of each frame

Behaviour:
- Reset, while resetn is low, asynchronously:
  - all counters are 0, pixel tick phase is 0
  - rd_addr=0, vga_colour=0, vga_hs=1, vga_vs=1, vga_blank_n=0, vga_pix_en=0, frame_start=0
- Pixel tick:
  - A toggle flop runs only while enable=1, so the tick is high every second clk.
  - All scan state advances only on clks where the tick is high.
- Counters:
  - h counts 0..H_TOTAL-1, where H_TOTAL = sum of the H_* parameters = 800.
  - At wrap, h returns to 0 and v increments.
  - v counts 0..V_TOTAL-1 (V_TOTAL = 525) and wraps to 0.
- Address, computed from the current (h,v):
  - rd_addr = (v>>2)*160 + (h>>2), implemented as ((v>>2)<<7) + ((v>>2)<<5) + (h>>2).
  - The sum is unsigned and 15 bits wide; the maximum in the active area is 19199.
  - Outside the active area rd_addr holds its last value; the data read there is don't-care.
  - rd_addr is registered.
- Pipeline:
  - Stage 1: (h,v) -> registered rd_addr, active flag, hs and vs.
  - Stage 2: rd_data is sampled 1 clk after the address and registered together with the delayed active/hs/vs.
  - Outputs for counter position (h,v) therefore appear 2 pixel ticks after the counters hold (h,v).
  - Sync and blank are delayed through matching stages so they stay aligned with colour.
- Active and sync regions:
  - active = (h<H_ACTIVE) && (v<V_ACTIVE).
  - vga_hs=0 for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC (656..751).
  - vga_vs=0 for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC (490..491).
  - When not active, vga_colour=0 and vga_blank_n=0.
- frame_start:
  - High for exactly one clk, on the tick where the counters wrap from (799,524) to (0,0).
  - Also high on the first tick after enable rises.
- Enable deasserted, at any point in a frame:
  - On the next clk the counters, tick phase and pipeline clear to their reset values and all outputs go to their reset values.
  - When enable rises again, the scan restarts at (0,0).
- Simultaneous events:
  - resetn low overrides enable.
  - An h wrap and a v wrap on the same tick count as a single frame wrap.

Optional Feature:
- Macro: VGA_FRAME_READER_BORDER_EN.
- When defined: vga_colour is forced to all ones during active pixels where logical x is 0 or 159, or logical y is 0 or 119 (x = h>>2, y = v>>2). This draws a 1-logical-pixel play-field border. The border flag is pipelined alongside colour with the same 2-tick delay.
- When undefined: colour always comes from rd_data; no extra logic is generated.

Decomposition:
- Package vga_pkg holds:
  - the timing constants (H_*, V_*, H_TOTAL, V_TOTAL)
  - LOGICAL_W=160, LOGICAL_H=120
  - ADDR_W=15, COLOUR_W=3
- Sub-module vga_timing_counter generates the h/v counters, active/hs/vs flags and the wrap pulse, gated by the pixel tick. vga_frame_reader instantiates it and adds the address generation and pipeline.

Test Plan:
- Reset: drive resetn low asynchronously mid-line.
  - Immediately, without waiting for a clk edge: vga_hs=1, vga_vs=1, vga_blank_n=0, vga_colour=0, rd_addr=0, frame_start=0.
- Line timing, with enable=1:
  - vga_hs line period = 1600 clk.
  - vga_hs is low for 192 clk, starting 2 ticks after h=656.
  - vga_blank_n is high for 1280 clk per line.
- Frame timing:
  - vga_vs is low for 2 lines (3200 clk), aligned to v=490.
  - frame_start pulses every 840000 clk and is exactly 1 clk wide.
- Addressing:
  - At (h=8, v=4): rd_addr=162.
  - At (h=639, v=479): rd_addr=19199.
  - At (h=3, v=3): rd_addr=0.
- Colour path: the RAM model returns rd_data = addr[2:0].
  - Active pixel at (h=8, v=4): vga_colour=3'd2, 2 ticks later.
  - At h=700 (blanking): vga_colour=0.
- Enable drop at (h=300, v=200):
  - Within 1 clk, all outputs are at their reset values.
  - On re-enable: frame_start pulses and the first active pixel shows the data for address 0.
